multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle controller FSM for the MIPS datapath: sequences fetch, decode, execute, memory and writeback over several cycles, using one shared ALU and one shared memory port.
- Decodes the same opcode set as the single-cycle control unit: R-type, addi, andi, ori, lw, sw, beq.
- Stretches memory states with a ready handshake.
- Sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
ILLEGAL_HALT, 1, 1 = unknown opcode enters HALT; 0 = unknown opcode treated as NOP (DECODE -> FETCH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory handshake: access completes in a cycle where mem_ready=1
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut
IRWrite  out  1  load IR
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<2
ZeroExt  out  1  immediate zero-extended (andi/ori)
RegWrite  out  1  register file write
RegDst  out  1  1 = rd, 0 = rt
state  out  4  current state (debug)
halted  out  1  FSM in HALT

Behaviour:
- Reset: rst_n=0 asynchronously forces state=FETCH (0). All outputs read 0 except the FETCH Moore values below; halted=0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, HALT 15. Encodings 12-14 are unreachable; if entered, next state is FETCH.
- Every output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01.
  - IRWrite=PCWrite=mem_ready (Mealy; a one-cycle pulse only).
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: ALUSrcB=11 (branch target). opcode is latched into op_q this cycle.
  - 000000 -> RTEX; 100011/101011 -> MEMADR; 000100 -> BEQEX; 001000/001100/001101 -> IMMEX.
  - Any other opcode -> HALT if ILLEGAL_HALT, else FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10. op_q=lw -> MEMRD; op_q=sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready, then -> FETCH.
  - MemWrite stays asserted for the whole wait.
- RTEX: ALUSrcA=1, ALUOp=010. -> RTWB.
- RTWB: RegWrite=1, RegDst=1. -> FETCH.
- BEQEX: ALUSrcA=1, ALUOp=001, PCWriteCond=1, PCSource=01. -> FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. -> IMMWB.
  - ALUOp from op_q: addi 000, andi 011, ori 100.
  - ZeroExt=1 for andi/ori.
- IMMWB: RegWrite=1, RegDst=0. -> FETCH.
- HALT: all control outputs 0, halted=1. Exit by reset only.
- Latency with mem_ready held 1: beq 3 cycles; R-type/addi/andi/ori/sw 4; lw 5. Each mem_ready=0 cycle in a memory state adds one cycle.
- opcode changes outside DECODE have no effect; op_q is the only source after DECODE.
- Reset mid-instruction aborts it: no RegWrite/MemWrite in the reset cycle, restart at FETCH.

Optional Feature:
JUMP_EN
- Defined: opcode 000010 in DECODE -> JEX. JEX drives PCWrite=1, PCSource=10, then -> FETCH; jump takes 3 cycles.
- Undefined: 000010 is illegal (HALT or NOP per ILLEGAL_HALT); JEX is unreachable; PCSource never 10.

Test Plan:
- Reset then R-type (000000), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7; IRWrite one pulse in cycle 0.
- lw (100011), mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemRead held through the wait; RegWrite=1 with MemtoReg=1 in state 4.
- sw (101011); opcode switched to 000000 after DECODE -> still 2 -> 5; MemWrite=1 with IorD=1; no RegWrite.
- beq (000100) -> states 0,1,8,0; ALUOp=001, PCWriteCond=1, PCSource=01 in state 8. ori (001101) -> IMMEX with ALUOp=100, ZeroExt=1.
- Opcode 111111 with ILLEGAL_HALT=1 -> state 15, halted=1, outputs 0 for 10 cycles; with ILLEGAL_HALT=0 -> back to state 0.
- rst_n pulsed low in state 4 (MEMWB) -> immediate state 0, RegWrite=0. With JUMP_EN, opcode 000010 -> 0,1,11,0 with PCSource=10.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Control FSM for a multi-cycle MIPS datapath. It steps each instruction
//   through fetch, decode, execute, memory and writeback, sharing one ALU and
//   one memory port. It supports R-type, addi, andi, ori, lw, sw and beq.
//   With JUMP_EN defined it also supports j.
//
// Configuration:
//   ILLEGAL_HALT (parameter) : 1 = an unknown opcode enters HALT.
//                              0 = an unknown opcode is a NOP (DECODE -> FETCH).
//   JUMP_EN (macro)          : when defined, opcode 000010 goes to JEX.
//                              When undefined, 000010 is an unknown opcode.
//
// Memory handshake:
//   In FETCH, MEMRD and MEMWR the request (MemRead or MemWrite) is held
//   steady. The access completes in the first cycle where mem_ready=1, and
//   the FSM leaves the state at the next clock edge. mem_ready is ignored in
//   every other state.
//
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   opcode[5:0]  : IR[31:26], sampled only in DECODE and latched into op_q
//   mem_ready    : memory access completes in a cycle where it is 1
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   PCSource[1:0], ALUOp[2:0], ALUSrcA, ALUSrcB[1:0], ZeroExt, RegWrite,
//   RegDst       : datapath mux selects and enables
//   state[3:0]   : current FSM state (debug)
//   halted       : FSM is in HALT
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ZeroExt,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [3:0] state,
   output logic       halted
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JEX    = 4'd11,
      S_HALT   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;

   // The opcode is captured while in DECODE. After that, op_q is the only
   // source of the opcode, so the IR field may change freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= 6'b000000;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = ALU_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ZeroExt     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      halted      = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            // IR and PC load only in the cycle the read completes. This makes
            // a one-cycle pulse, however long the fetch waits.
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            // The ALU computes the branch target early, in case this is a beq.
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:                   state_d = S_RTEX;
               OP_LW, OP_SW:               state_d = S_MEMADR;
               OP_BEQ:                     state_d = S_BEQEX;
               OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IMMEX;
`ifdef JUMP_EN
               OP_J:                       state_d = S_JEX;
`endif
               default:                    state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
            endcase
         end

         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         end

         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end
         end

         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            state_d  = S_FETCH;
         end

         S_MEMWR: begin
            // The write request is held for the whole wait. It is not pulsed.
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end
         end

         S_RTEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
            state_d = S_RTWB;
         end

         S_RTWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            state_d  = S_FETCH;
         end

         S_BEQEX: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            state_d     = S_FETCH;
         end

         S_IMMEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (op_q)
               OP_ANDI: begin
                  ALUOp   = ALU_AND;
                  ZeroExt = 1'b1;
               end
               OP_ORI: begin
                  ALUOp   = ALU_OR;
                  ZeroExt = 1'b1;
               end
               default: ALUOp = ALU_ADD;
            endcase
            state_d = S_IMMWB;
         end

         S_IMMWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end

`ifdef JUMP_EN
         S_JEX: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            state_d  = S_FETCH;
         end
`endif

         S_HALT: begin
            // Only reset can leave HALT.
            halted  = 1'b1;
            state_d = S_HALT;
         end

         // This also covers the unused encodings 12-14 (and JEX when jumps are
         // disabled). Recover to FETCH with all outputs inactive.
         default: state_d = S_FETCH;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Bench for multicycle_control. There are two instances on shared inputs:
//   dut     : ILLEGAL_HALT=1
//   dut_nop : ILLEGAL_HALT=0 (checked only in the illegal-opcode scenario)
//
// The reference model expands each instruction into its list of expected
// cycles from the instruction class and the memory wait counts. Each cycle
// gets the expected state and control vector, plus the mem_ready and opcode
// values to drive. Inputs change on the falling edge and outputs are sampled
// 1 time unit later.
// Build with +define+JUMP_EN to cover the jump instruction.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                  ST_MEMWB = 4, ST_MEMWR = 5, ST_RTEX = 6, ST_RTWB = 7,
                  ST_BEQEX = 8, ST_IMMEX = 9, ST_IMMWB = 10, ST_JEX = 11,
                  ST_HALT = 15;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000,
                          OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                          OP_J = 6'b000010, OP_BAD = 6'b111111;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'b0;
   logic       mem_ready = 1'b0;

   always #5 clk = ~clk;

   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic [1:0] PCSource, ALUSrcB;
   logic [2:0] ALUOp;
   logic       ALUSrcA, ZeroExt, RegWrite, RegDst, halted;
   logic [3:0] state;

   logic       n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_MemtoReg, n_IRWrite;
   logic [1:0] n_PCSource, n_ALUSrcB;
   logic [2:0] n_ALUOp;
   logic       n_ALUSrcA, n_ZeroExt, n_RegWrite, n_RegDst, n_halted;
   logic [3:0] n_state;

   multicycle_control #(.ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
      .RegWrite(RegWrite), .RegDst(RegDst), .state(state), .halted(halted)
   );

   multicycle_control #(.ILLEGAL_HALT(1'b0)) dut_nop (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD),
      .MemRead(n_MemRead), .MemWrite(n_MemWrite), .MemtoReg(n_MemtoReg),
      .IRWrite(n_IRWrite), .PCSource(n_PCSource), .ALUOp(n_ALUOp),
      .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ZeroExt(n_ZeroExt),
      .RegWrite(n_RegWrite), .RegDst(n_RegDst), .state(n_state), .halted(n_halted)
   );

   logic [18:0] ctrl_vec;
   assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                      PCSource, ALUOp, ALUSrcA, ALUSrcB, ZeroExt, RegWrite, RegDst, halted};

   // ---------------- scoreboard ----------------
   logic [22:0] exp_q[$];   // {state, ctrl}
   logic        rdy_q[$];
   logic [5:0]  opc_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // Expected control vector for a state, taken from the per-state output table.
   function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] iop, input logic rdy);
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, zext, rw, rdst, hlt;
      logic [1:0] pcsrc, srcb;
      logic [2:0] aop;
      {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, zext, rw, rdst, hlt} = '0;
      pcsrc = 2'b00; srcb = 2'b00; aop = 3'b000;
      case (st)
         ST_FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         ST_DECODE: srcb = 2'b11;
         ST_MEMADR: begin srca = 1; srcb = 2'b10; end
         ST_MEMRD:  begin mrd = 1; iord = 1; end
         ST_MEMWB:  begin rw = 1; m2r = 1; end
         ST_MEMWR:  begin mwr = 1; iord = 1; end
         ST_RTEX:   begin srca = 1; aop = 3'b010; end
         ST_RTWB:   begin rw = 1; rdst = 1; end
         ST_BEQEX:  begin srca = 1; aop = 3'b001; pcwc = 1; pcsrc = 2'b01; end
         ST_IMMEX: begin
            srca = 1; srcb = 2'b10;
            aop  = (iop == OP_ANDI) ? 3'b011 : (iop == OP_ORI) ? 3'b100 : 3'b000;
            zext = (iop == OP_ANDI) || (iop == OP_ORI);
         end
         ST_IMMWB:  rw = 1;
         ST_JEX:    begin pcw = 1; pcsrc = 2'b10; end
         ST_HALT:   hlt = 1;
         default:   ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcsrc, aop, srca, srcb, zext, rw, rdst, hlt};
   endfunction

   function automatic logic [5:0] rand_op();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic push_cycle(input int st, input logic rdy, input logic [5:0] dop, input logic [5:0] iop);
      exp_q.push_back({4'(st), exp_ctrl(st, iop, rdy)});
      rdy_q.push_back(rdy);
      opc_q.push_back(dop);
   endtask

   // Reference model for one legal instruction. fw = fetch wait cycles,
   // mw = wait cycles in the memory state. After DECODE the opcode input
   // carries after_op, or random values when rnd_after is set.
   task automatic build_instr(input logic [5:0] op, input int fw, input int mw,
                              input logic [5:0] after_op, input bit rnd_after);
      logic [5:0] ao;
      for (int i = 0; i < fw; i++) push_cycle(ST_FETCH, 1'b0, rand_op(), op);
      push_cycle(ST_FETCH, 1'b1, rand_op(), op);
      push_cycle(ST_DECODE, 1'($urandom_range(0, 1)), op, op);
      ao = rnd_after ? rand_op() : after_op;
      case (op)
         OP_R: begin
            push_cycle(ST_RTEX, 1'($urandom_range(0, 1)), ao, op);
            push_cycle(ST_RTWB, 1'($urandom_range(0, 1)), ao, op);
         end
         OP_LW, OP_SW: begin
            push_cycle(ST_MEMADR, 1'($urandom_range(0, 1)), ao, op);
            for (int i = 0; i < mw; i++)
               push_cycle((op == OP_LW) ? ST_MEMRD : ST_MEMWR, 1'b0, rnd_after ? rand_op() : ao, op);
            push_cycle((op == OP_LW) ? ST_MEMRD : ST_MEMWR, 1'b1, ao, op);
            if (op == OP_LW) push_cycle(ST_MEMWB, 1'($urandom_range(0, 1)), ao, op);
         end
         OP_BEQ: push_cycle(ST_BEQEX, 1'($urandom_range(0, 1)), ao, op);
         OP_J:   push_cycle(ST_JEX, 1'($urandom_range(0, 1)), ao, op);
         default: begin
            push_cycle(ST_IMMEX, 1'($urandom_range(0, 1)), ao, op);
            push_cycle(ST_IMMWB, 1'($urandom_range(0, 1)), ao, op);
         end
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input logic rdy, input logic [5:0] op);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [22:0] exp;
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      opcode = rand_op();
      #1;
      exp = {4'(ST_FETCH), exp_ctrl(ST_FETCH, 6'b0, 1'b0)};
      n_checks++;
      if ({state, ctrl_vec} !== exp)
         $display("FAIL reset_state: got st=%0d ctrl=%b, want st=%0d ctrl=%b", state, ctrl_vec, exp[22:19], exp[18:0]);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [22:0] exp;
      int cyc = 0;
      build_instr(OP_R,   0, 0, 6'b0, 1'b1);   // 0,1,6,7
      build_instr(OP_LW,  0, 2, 6'b0, 1'b1);   // 0,1,2,3,3,3,4
      build_instr(OP_SW,  0, 1, OP_R, 1'b0);   // opcode flips to R-type after DECODE
      build_instr(OP_BEQ, 0, 0, 6'b0, 1'b1);   // 0,1,8
      build_instr(OP_ORI, 1, 0, 6'b0, 1'b1);
      build_instr(OP_ANDI, 0, 0, 6'b0, 1'b1);
      build_instr(OP_ADDI, 2, 0, 6'b0, 1'b1);
      while (exp_q.size() > 0) begin
         drive_cycle(rdy_q.pop_front(), opc_q.pop_front());
         exp = exp_q.pop_front();
         n_checks++;
         if ({state, ctrl_vec} !== exp)
            $display("FAIL directed cyc%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b", cyc, state, ctrl_vec, exp[22:19], exp[18:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_random();
      logic [22:0] exp;
      logic [5:0]  ops[8];
      int cyc = 0;
      int nops = 7;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
`ifdef JUMP_EN
      nops = 8;
`endif
      for (int k = 0; k < 30; k++)
         build_instr(ops[$urandom_range(0, nops - 1)], $urandom_range(0, 2), $urandom_range(0, 2), 6'b0, 1'b1);
      while (exp_q.size() > 0) begin
         drive_cycle(rdy_q.pop_front(), opc_q.pop_front());
         exp = exp_q.pop_front();
         n_checks++;
         if ({state, ctrl_vec} !== exp)
            $display("FAIL random cyc%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b", cyc, state, ctrl_vec, exp[22:19], exp[18:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_jump();
      logic [22:0] exp;
      int cyc = 0;
      build_instr(OP_J, 0, 0, 6'b0, 1'b1);      // 0,1,11
      build_instr(OP_BEQ, 0, 0, 6'b0, 1'b1);    // jump must return to FETCH
      while (exp_q.size() > 0) begin
         drive_cycle(rdy_q.pop_front(), opc_q.pop_front());
         exp = exp_q.pop_front();
         n_checks++;
         if ({state, ctrl_vec} !== exp)
            $display("FAIL jump cyc%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b", cyc, state, ctrl_vec, exp[22:19], exp[18:0]);
         else n_pass++;
         cyc++;
      end
   endtask

   task automatic test_reset_mid();
      logic [22:0] exp;
      int cyc = 0;
      build_instr(OP_LW, 0, 0, 6'b0, 1'b1);     // ends with the MEMWB cycle
      while (exp_q.size() > 0) begin
         drive_cycle(rdy_q.pop_front(), opc_q.pop_front());
         exp = exp_q.pop_front();
         n_checks++;
         if ({state, ctrl_vec} !== exp)
            $display("FAIL reset_mid_pre cyc%0d: got st=%0d ctrl=%b, want st=%0d ctrl=%b", cyc, state, ctrl_vec, exp[22:19], exp[18:0]);
         else n_pass++;
         cyc++;
      end
      // We are now in MEMWB. Pull reset mid-cycle; the abort must take effect at once.
      #1;
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({state, RegWrite, MemWrite} !== {4'(ST_FETCH), 1'b0, 1'b0})
         $display("FAIL reset_mid: got st=%0d RegWrite=%b MemWrite=%b, want st=0 RegWrite=0 MemWrite=0", state, RegWrite, MemWrite);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Unknown opcode: dut halts and holds all controls at 0; dut_nop returns to FETCH.
   task automatic test_illegal(input logic [5:0] bad);
      drive_cycle(1'b1, rand_op());   // FETCH completes
      drive_cycle(1'b0, bad);         // DECODE
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), rand_op());
         n_checks++;
         if ({state, ctrl_vec} !== {4'(ST_HALT), 19'b1})
            $display("FAIL halt op=%b cyc%0d: got st=%0d ctrl=%b, want st=15 ctrl=%b", bad, i, state, ctrl_vec, 19'b1);
         else n_pass++;
         if (i == 0) begin
            n_checks++;
            if ({n_state, n_halted} !== {4'(ST_FETCH), 1'b0})
               $display("FAIL nop op=%b: got st=%0d halted=%b, want st=0 halted=0", bad, n_state, n_halted);
            else n_pass++;
         end
      end
      apply_reset();
      #1;
      n_checks++;
      if ({state, halted} !== {4'(ST_FETCH), 1'b0})
         $display("FAIL halt_exit: got st=%0d halted=%b, want st=0 halted=0", state, halted);
      else n_pass++;
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
`ifdef JUMP_EN
      test_jump();
`else
      test_illegal(OP_J);
`endif
      test_illegal(OP_BAD);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
